// File: rtl/serial_comparator_ctrl.sv
// Serial MSB-first magnitude comparator sequencer driving an external 1-bit comparator.
// Optional SERCMP_EARLY_EXIT_EN: finish as soon as the first differing bit is seen.
module serial_comparator_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             bit_a,
  output logic             bit_b,
  input  logic             cmp_greater,
  input  logic             cmp_less,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  typedef enum logic [1:0] {DecEq, DecGt, DecLt} dec_e;

  state_e           state_q, state_d;
  dec_e             dec_q, dec_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             greater_q, greater_d, less_q, less_d, equal_q, equal_d;
  logic             last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dec_q     <= DecEq;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      greater_q <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      greater_q <= greater_d;
      less_q    <= less_d;
      equal_q   <= equal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    greater_d = greater_q;
    less_d    = less_q;
    equal_d   = equal_q;
    busy      = 1'b0;
    done      = 1'b0;
    bit_a     = 1'b0;
    bit_b     = 1'b0;
    last      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          cnt_d   = CntW'(WIDTH);
          dec_d   = DecEq;
          state_d = StRun;
        end
      end
      StRun: begin
        busy   = 1'b1;
        bit_a  = a_sh_q[WIDTH-1];
        bit_b  = b_sh_q[WIDTH-1];
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CntW'(1);
        // First differing bit decides; greater has priority if both are flagged.
        if (dec_q == DecEq) begin
          if (cmp_greater)   dec_d = DecGt;
          else if (cmp_less) dec_d = DecLt;
        end
`ifdef SERCMP_EARLY_EXIT_EN
        last = (cnt_q == CntW'(1)) || cmp_greater || cmp_less;
`else
        last = (cnt_q == CntW'(1));
`endif
        if (last) begin
          state_d   = StDone;
          greater_d = (dec_d == DecGt);
          less_d    = (dec_d == DecLt);
          equal_d   = (dec_d == DecEq);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign greater = greater_q;
  assign less    = less_q;
  assign equal   = equal_q;

endmodule
